// File: rtl/deinterleaver_prime_stream.sv
// deinterleaver_prime_stream: ping-pong buffer undoing the (P*i) mod N prime interleave.
module deinterleaver_prime_stream #(
   parameter int BITS = 8,
   parameter int N    = 10,
   parameter int P    = 3
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_s_valid,
   output logic            o_s_ready,
   input  logic [BITS-1:0] i_s_data,
   output logic            o_m_valid,
   input  logic            i_m_ready,
   output logic [BITS-1:0] o_m_data,
   output logic            o_m_last
);
   localparam int AW = $clog2(N + P);
   localparam int IW = $clog2(N);

   logic [BITS-1:0] r_mem [2][N];
   logic [1:0]      r_full;
   logic            r_wb;
   logic            r_rb;
   logic [AW-1:0]   r_wa;
   logic [AW-1:0]   r_wcnt;
   logic [AW-1:0]   r_rcnt;
   logic [AW-1:0]   w_wa_sum;
   logic            w_wr;
   logic            w_rd;
   logic            w_wdone;
   logic            w_rdone;
   logic [1:0]      w_set;
   logic [1:0]      w_clr;

   assign o_s_ready = !r_full[r_wb];
   assign o_m_valid = r_full[r_rb];
   assign o_m_data  = r_mem[r_rb][r_rcnt[IW-1:0]];
   assign o_m_last  = o_m_valid && r_rcnt == AW'(N - 1);
   assign w_wr      = i_s_valid && o_s_ready;
   assign w_rd      = o_m_valid && i_m_ready;
   assign w_wdone   = w_wr && r_wcnt == AW'(N - 1);
   assign w_rdone   = w_rd && o_m_last;
   assign w_wa_sum  = r_wa + AW'(P);
   // Set and clear can never target the same bank: writes need it empty, reads need it full.
   assign w_set     = {w_wdone && r_wb, w_wdone && !r_wb};
   assign w_clr     = {w_rdone && r_rb, w_rdone && !r_rb};

   always_ff @(posedge i_clk)
      if (w_wr) r_mem[r_wb][r_wa[IW-1:0]] <= i_s_data;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_full <= '0;
         r_wb   <= 1'b0;
         r_rb   <= 1'b0;
         r_wa   <= '0;
         r_wcnt <= '0;
         r_rcnt <= '0;
      end else begin
         r_full <= (r_full | w_set) & ~w_clr;
         if (w_wr) begin
            r_wa   <= w_wdone ? '0 : (w_wa_sum >= AW'(N) ? w_wa_sum - AW'(N) : w_wa_sum);
            r_wcnt <= w_wdone ? '0 : r_wcnt + AW'(1);
            r_wb   <= r_wb ^ w_wdone;
         end
         if (w_rd) begin
            r_rcnt <= w_rdone ? '0 : r_rcnt + AW'(1);
            r_rb   <= r_rb ^ w_rdone;
         end
      end
   end
endmodule

// File: tb/tb_deinterleaver_prime_stream.sv
// tb_deinterleaver_prime_stream: directed checks of the inverse prime-interleave stream buffer.
module tb_deinterleaver_prime_stream;
   logic       clk = 1'b0;
   logic       rst;
   logic       s_valid, s_ready, m_valid, m_ready, m_last;
   logic [7:0] s_data, m_data;
   logic       a_sv, a_sr, a_mv, a_ml;
   logic [7:0] a_sd, a_md;
   logic       b_sv, b_sr, b_mv, b_ml;
   logic [7:0] b_sd, b_md;
   logic       d_sv, d_sr, d_mv, d_ml;
   logic [7:0] d_sd, d_md;
   int n_cmp = 0;
   int n_err = 0;
   int t10 [10] = '{0, 7, 4, 1, 8, 5, 2, 9, 6, 3};
   int t7  [7]  = '{0, 4, 1, 5, 2, 6, 3};
   int t16 [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};
   int t2  [2]  = '{0, 1};

   always #5 clk = ~clk;

   deinterleaver_prime_stream #(.BITS(8), .N(10), .P(3)) dut (
      .i_clk(clk), .i_reset(rst), .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_data(s_data),
      .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data), .o_m_last(m_last));
   deinterleaver_prime_stream #(.BITS(8), .N(7), .P(2)) u7 (
      .i_clk(clk), .i_reset(rst), .i_s_valid(a_sv), .o_s_ready(a_sr), .i_s_data(a_sd),
      .o_m_valid(a_mv), .i_m_ready(1'b1), .o_m_data(a_md), .o_m_last(a_ml));
   deinterleaver_prime_stream #(.BITS(8), .N(16), .P(5)) u16 (
      .i_clk(clk), .i_reset(rst), .i_s_valid(b_sv), .o_s_ready(b_sr), .i_s_data(b_sd),
      .o_m_valid(b_mv), .i_m_ready(1'b1), .o_m_data(b_md), .o_m_last(b_ml));
   deinterleaver_prime_stream #(.BITS(8), .N(2), .P(1)) u2 (
      .i_clk(clk), .i_reset(rst), .i_s_valid(d_sv), .o_s_ready(d_sr), .i_s_data(d_sd),
      .o_m_valid(d_mv), .i_m_ready(1'b1), .o_m_data(d_md), .o_m_last(d_ml));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
      a_sv = 1'b0; b_sv = 1'b0; d_sv = 1'b0;
      a_sd = '0; b_sd = '0; d_sd = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
      n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
      n_cmp++; if (m_last !== 1'b0) begin n_err++; $display("FAIL reset_m_last got %b want 0", m_last); end
   endtask

   task automatic test_single_frame;
      int k;
      k = 0;
      do_reset();
      m_ready = 1'b1;
      for (int c = 0; c < 25; c++) begin
         s_valid = (c < 10);
         s_data = 8'(c);
         if (c <= 10) begin
            n_cmp++;
            if (m_valid !== (c == 10)) begin n_err++; $display("FAIL single_latency c=%0d got %b want %b", c, m_valid, c == 10); end
         end
         if (m_valid) begin
            if (k < 10) begin
               n_cmp++; if (m_data !== 8'(t10[k])) begin n_err++; $display("FAIL single_data k=%0d got %0d want %0d", k, m_data, t10[k]); end
               n_cmp++; if (m_last !== (k == 9)) begin n_err++; $display("FAIL single_last k=%0d got %b want %b", k, m_last, k == 9); end
            end
            k++;
         end
         tick();
      end
      s_valid = 1'b0;
      n_cmp++; if (k !== 10) begin n_err++; $display("FAIL single_count got %0d want 10", k); end
   endtask

   task automatic test_back_to_back;
      int k;
      k = 0;
      do_reset();
      m_ready = 1'b1;
      for (int c = 0; c < 45; c++) begin
         s_valid = (c < 30);
         s_data = 8'(100 + c);
         if (c < 30) begin
            n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL b2b_s_ready c=%0d got %b want 1", c, s_ready); end
         end
         if (c >= 10 && c < 40) begin
            n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL b2b_gap c=%0d got %b want 1", c, m_valid); end
         end
         if (m_valid) begin
            if (k < 30) begin
               n_cmp++; if (m_data !== 8'(100 + (k / 10) * 10 + t10[k % 10])) begin n_err++; $display("FAIL b2b_data k=%0d got %0d want %0d", k, m_data, 100 + (k / 10) * 10 + t10[k % 10]); end
               n_cmp++; if (m_last !== (k % 10 == 9)) begin n_err++; $display("FAIL b2b_last k=%0d got %b want %b", k, m_last, k % 10 == 9); end
            end
            k++;
         end
         tick();
      end
      s_valid = 1'b0;
      n_cmp++; if (k !== 30) begin n_err++; $display("FAIL b2b_count got %0d want 30", k); end
   endtask

   task automatic test_backpressure;
      int acc;
      int k;
      acc = 0;
      k = 0;
      do_reset();
      m_ready = 1'b0;
      for (int c = 0; c < 25; c++) begin
         s_valid = 1'b1;
         s_data = 8'(c);
         if (s_ready) acc++;
         if (m_valid) begin
            n_cmp++; if (m_data !== 8'd0) begin n_err++; $display("FAIL bp_hold c=%0d got %0d want 0", c, m_data); end
         end
         tick();
      end
      s_valid = 1'b0;
      n_cmp++; if (acc !== 20) begin n_err++; $display("FAIL bp_accepted got %0d want 20", acc); end
      n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL bp_s_ready got %b want 0", s_ready); end
      n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL bp_m_valid got %b want 1", m_valid); end
      m_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (m_valid) begin
            if (k < 20) begin
               n_cmp++; if (m_data !== 8'((k / 10) * 10 + t10[k % 10])) begin n_err++; $display("FAIL bp_drain k=%0d got %0d want %0d", k, m_data, (k / 10) * 10 + t10[k % 10]); end
            end
            k++;
         end
         tick();
      end
      n_cmp++; if (k !== 20) begin n_err++; $display("FAIL bp_drain_count got %0d want 20", k); end
   endtask

   task automatic test_random;
      int in_i;
      int out_k;
      logic [7:0] prev;
      bit stalled;
      in_i = 0;
      out_k = 0;
      prev = '0;
      stalled = 1'b0;
      do_reset();
      for (int cyc = 0; cyc < 6000 && out_k < 500; cyc++) begin
         s_valid = (in_i < 500) && ($urandom_range(0, 3) != 0);
         s_data = 8'(in_i);
         m_ready = ($urandom_range(0, 2) != 0);
         if (stalled) begin
            n_cmp++; if (m_data !== prev) begin n_err++; $display("FAIL rnd_stable cyc=%0d got %0d want %0d", cyc, m_data, prev); end
         end
         if (s_valid && s_ready) in_i++;
         if (m_valid && m_ready) begin
            n_cmp++; if (m_data !== 8'((out_k / 10) * 10 + t10[out_k % 10])) begin n_err++; $display("FAIL rnd_data k=%0d got %0d want %0d", out_k, m_data, 8'((out_k / 10) * 10 + t10[out_k % 10])); end
            n_cmp++; if (m_last !== (out_k % 10 == 9)) begin n_err++; $display("FAIL rnd_last k=%0d got %b want %b", out_k, m_last, out_k % 10 == 9); end
            out_k++;
         end
         stalled = m_valid && !m_ready;
         prev = m_data;
         tick();
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      n_cmp++; if (out_k !== 500) begin n_err++; $display("FAIL rnd_count got %0d want 500", out_k); end
      for (int c = 0; c < 5; c++) begin
         n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rnd_extra c=%0d got %b want 0", c, m_valid); end
         tick();
      end
   endtask

   task automatic test_mid_reset;
      int k;
      k = 0;
      do_reset();
      m_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         s_valid = 1'b1;
         s_data = 8'(50 + c);
         tick();
      end
      rst = 1'b1;
      s_valid = 1'b0;
      tick();
      rst = 1'b0;
      n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL mid_m_valid got %b want 0", m_valid); end
      n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL mid_s_ready got %b want 1", s_ready); end
      for (int c = 0; c < 25; c++) begin
         s_valid = (c < 10);
         s_data = 8'(200 + c);
         if (c < 10) begin
            n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL mid_early c=%0d got %b want 0", c, m_valid); end
         end
         if (m_valid) begin
            if (k < 10) begin
               n_cmp++; if (m_data !== 8'(200 + t10[k])) begin n_err++; $display("FAIL mid_data k=%0d got %0d want %0d", k, m_data, 200 + t10[k]); end
            end
            k++;
         end
         tick();
      end
      s_valid = 1'b0;
      n_cmp++; if (k !== 10) begin n_err++; $display("FAIL mid_count got %0d want 10", k); end
   endtask

   task automatic test_sweep;
      int ka, kb, kd;
      ka = 0; kb = 0; kd = 0;
      do_reset();
      for (int c = 0; c < 40; c++) begin
         a_sv = (c < 7);  a_sd = 8'(c);
         b_sv = (c < 16); b_sd = 8'(c);
         d_sv = (c < 2);  d_sd = 8'(c);
         if (a_mv) begin
            if (ka < 7) begin
               n_cmp++; if (a_md !== 8'(t7[ka]) || a_ml !== (ka == 6)) begin n_err++; $display("FAIL sweep7 k=%0d got %0d/%b want %0d/%b", ka, a_md, a_ml, t7[ka], ka == 6); end
            end
            ka++;
         end
         if (b_mv) begin
            if (kb < 16) begin
               n_cmp++; if (b_md !== 8'(t16[kb]) || b_ml !== (kb == 15)) begin n_err++; $display("FAIL sweep16 k=%0d got %0d/%b want %0d/%b", kb, b_md, b_ml, t16[kb], kb == 15); end
            end
            kb++;
         end
         if (d_mv) begin
            if (kd < 2) begin
               n_cmp++; if (d_md !== 8'(t2[kd]) || d_ml !== (kd == 1)) begin n_err++; $display("FAIL sweep2 k=%0d got %0d/%b want %0d/%b", kd, d_md, d_ml, t2[kd], kd == 1); end
            end
            kd++;
         end
         tick();
      end
      n_cmp++; if (ka !== 7) begin n_err++; $display("FAIL sweep7_count got %0d want 7", ka); end
      n_cmp++; if (kb !== 16) begin n_err++; $display("FAIL sweep16_count got %0d want 16", kb); end
      n_cmp++; if (kd !== 2) begin n_err++; $display("FAIL sweep2_count got %0d want 2", kd); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_mid_reset();
      test_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/deinterleaver_prime_stream.md
DEINTERLEAVER_PRIME_STREAM -- requirements
Module: deinterleaver_prime_stream

Interface
REQ-001 The block SHALL have parameter BITS, default 8, sample width in bits.
REQ-002 The block SHALL have parameter N, default 10, frame length in samples, N >= 2.
REQ-003 The block SHALL have parameter P, default 3, interleave multiplier, 1 <= P < N and gcd(P,N) = 1.
REQ-004 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 s_valid  input  1  input sample valid.
REQ-008 s_ready  output  1  block can accept an input sample.
REQ-009 s_data  input  BITS  interleaved input sample.
REQ-010 m_valid  output  1  output sample valid.
REQ-011 m_ready  input  1  downstream accepts the output sample.
REQ-012 m_data  output  BITS  deinterleaved output sample.
REQ-013 m_last  output  1  high with the final (index N-1) sample of a frame.

Function
REQ-014 Permutation SHALL be the inverse of the prime interleave: output index (P*i) mod N SHALL carry input sample i of the same frame.
REQ-015 Storage SHALL be two banks of N x BITS words (ping-pong); each bank has a registered FULL flag.
REQ-016 Write address SHALL be an accumulator: 0 at frame start, then wa = wa+P, minus N if result >= N; no multiplier or divider.
REQ-017 Accumulator and counters SHALL be sized to hold 0..N-1+P without overflow.
REQ-018 An input transfer SHALL occur when s_valid && s_ready; the sample is written to the write bank at wa.
REQ-019 s_ready SHALL equal NOT FULL of the current write bank, from registered state only.
REQ-020 On the Nth input transfer of a frame, the write bank SHALL be marked FULL, the write-bank pointer SHALL toggle, and wa and the write count SHALL return to 0.
REQ-021 Read side SHALL output the read bank sequentially, index 0..N-1; m_data SHALL be word rcnt of the read bank.
REQ-022 m_valid SHALL equal FULL of the current read bank; m_data and m_last SHALL hold stable while m_valid && !m_ready.
REQ-023 An output transfer SHALL occur when m_valid && m_ready; rcnt SHALL advance; m_last SHALL be high when rcnt = N-1.
REQ-024 On the transfer with m_last, the read bank SHALL be cleared from FULL, the read pointer SHALL toggle, and rcnt SHALL return to 0.
REQ-025 Latency: m_valid SHALL rise on the cycle after the Nth input transfer when that bank's read side is idle.
REQ-026 Throughput: with both sides always ready, one sample per cycle in and out SHALL be sustained with no bubbles across frames.
REQ-027 With both banks FULL, s_ready SHALL be 0 until the read side frees a bank.
REQ-028 When a bank is freed (last read) and written in the same cycle, the FULL update SHALL be per bank without conflict; a freed bank's s_ready rises the following cycle.
REQ-029 A bank whose FULL flag is clear SHALL never be presented on the output.

Reset
REQ-030 When reset is high at a clock edge, both FULL flags, bank pointers, wa, the write count and rcnt SHALL clear to 0.
REQ-031 After reset, s_ready SHALL be 1 and m_valid and m_last SHALL be 0; m_data SHALL be don't-care.
REQ-032 Reset mid-frame SHALL discard all partial and buffered frames; memory contents SHALL NOT be cleared.

Verification
REQ-033 Input 0..9 (N=10, P=3), m_ready=1 -> output 0,7,4,1,8,5,2,9,6,3; m_last on the 10th output; m_valid rises the cycle after input 9.
REQ-034 Three back-to-back frames, both sides always ready -> s_ready stays 1, 30 outputs with no gaps, each frame correctly permuted.
REQ-035 m_ready=0 throughout, 25 inputs offered -> exactly 20 accepted, s_ready=0 afterward; m_data=0 is held stable.
REQ-036 Random s_valid/m_ready toggling over 50 frames -> output equals the scoreboard inverse permutation; no loss or duplication.
REQ-037 Reset asserted after 6 inputs of frame 1 -> no output appears; the next 10 inputs form a correct frame.
REQ-038 Parameter sweep (N=7,P=2), (N=16,P=5), (N=2,P=1) -> inverse of (P*i) mod N holds for each.
